// File: rtl/even_parity_pkg.sv
// Shared widths and codeword type for the even-parity generator/checker.
// EVEN_PARITY_CHECK_EN (defined elsewhere) enables the optional codeword checker in the top.
package even_parity_pkg;

  localparam int DATA_W_DEF = 3;
  localparam int CW_W       = DATA_W_DEF + 1;

  typedef logic [CW_W-1:0] codeword_t;

  // Builds {data, parity} for the default width; handy for checkers and models.
  function automatic codeword_t make_codeword(input logic [DATA_W_DEF-1:0] data);
    return {data, ^data};
  endfunction

endpackage

// File: rtl/parity_tree.sv
// Purely combinational XOR reduction over a parameterised bus.
// Built as a balanced pairwise tree so depth grows with log2(W).
module parity_tree #(
  parameter int W = 3
) (
  input  logic [W-1:0] data,
  output logic         parity
);

  localparam int LEVELS = (W <= 1) ? 1 : $clog2(W);
  localparam int PAD_W  = 1 << LEVELS;

  logic [PAD_W-1:0] padded;
  logic [PAD_W-1:0] stage [0:LEVELS];

  // Zero padding leaves the XOR result unchanged.
  always_comb begin
    padded = '0;
    padded[W-1:0] = data;
  end

  assign stage[0] = padded;

  for (genvar lvl = 0; lvl < LEVELS; lvl++) begin : g_level
    localparam int NODES = PAD_W >> (lvl + 1);
    for (genvar n = 0; n < PAD_W; n++) begin : g_node
      if (n < NODES) begin : g_xor
        assign stage[lvl+1][n] = stage[lvl][2*n] ^ stage[lvl][2*n+1];
      end else begin : g_zero
        assign stage[lvl+1][n] = 1'b0;
      end
    end
  end

  assign parity = stage[LEVELS][0];

endmodule

// File: rtl/even_parity_fourbit.sv
// Registered even-parity generator: Out = {A, ^A}, one-cycle latency, sync active-high reset.
// Define EVEN_PARITY_CHECK_EN to add chk_in/chk_err, a registered parity check of an incoming codeword.
module even_parity_fourbit
  import even_parity_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] A,
`ifdef EVEN_PARITY_CHECK_EN
  input  logic [DATA_W:0]   chk_in,
  output logic              chk_err,
`endif
  output logic              parity_bit,
  output logic [DATA_W:0]   Out
);

  logic gen_parity;

  parity_tree #(.W(DATA_W)) u_gen_tree (
    .data   (A),
    .parity (gen_parity)
  );

  // A is sampled every edge; reset wins over sampling.
  always_ff @(posedge clk) begin
    if (rst) begin
      parity_bit <= 1'b0;
      Out        <= '0;
    end else begin
      parity_bit <= gen_parity;
      Out        <= {A, gen_parity};
    end
  end

`ifdef EVEN_PARITY_CHECK_EN
  logic chk_parity;

  // Odd number of ones in a received codeword means it is corrupt.
  parity_tree #(.W(DATA_W+1)) u_chk_tree (
    .data   (chk_in),
    .parity (chk_parity)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err <= 1'b0;
    end else begin
      chk_err <= chk_parity;
    end
  end
`endif

endmodule

// File: tb/tb_even_parity_fourbit.sv
// Bench for even_parity_fourbit: truth-table vectors, directed reset/stream sequences,
// and randomized stimulus against a count-the-ones reference model.
module tb_even_parity_fourbit;

  logic       clk;
  logic       rst;
  logic [2:0] A;
  logic       parity_bit;
  logic [3:0] Out;
`ifdef EVEN_PARITY_CHECK_EN
  logic [3:0] chk_in;
  logic       chk_err;
`endif

  int n_tests;
  int n_fail;

  even_parity_fourbit #(.DATA_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
`ifdef EVEN_PARITY_CHECK_EN
    .chk_in     (chk_in),
    .chk_err    (chk_err),
`endif
    .parity_bit (parity_bit),
    .Out        (Out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] a;
    logic       exp_p;
    logic [3:0] exp_out;
  } vec_t;

  vec_t vecs [8];

  // Reference: parity is 1 when A holds an odd count of ones.
  function automatic logic model_parity(input logic [31:0] v, input int width);
    int ones;
    ones = 0;
    for (int i = 0; i < width; i++) ones += int'(v[i]);
    return (ones % 2) == 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_gen(input string name, input logic exp_p, input logic [3:0] exp_out);
    check({name, ".parity"}, {31'd0, parity_bit}, {31'd0, exp_p});
    check({name, ".out"}, {28'd0, Out}, {28'd0, exp_out});
  endtask

  initial begin
    logic [2:0] r_a;
    logic       r_rst;
    logic       ep;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    A   = 3'b101;
`ifdef EVEN_PARITY_CHECK_EN
    chk_in = 4'b0000;
`endif

    vecs[0] = '{3'b000, 1'b0, 4'b0000};
    vecs[1] = '{3'b001, 1'b1, 4'b0011};
    vecs[2] = '{3'b010, 1'b1, 4'b0101};
    vecs[3] = '{3'b011, 1'b0, 4'b0110};
    vecs[4] = '{3'b100, 1'b1, 4'b1001};
    vecs[5] = '{3'b101, 1'b0, 4'b1010};
    vecs[6] = '{3'b110, 1'b0, 4'b1100};
    vecs[7] = '{3'b111, 1'b1, 4'b1111};

    // Reset held 2 cycles with A=101
    for (int i = 0; i < 2; i++) begin
      step();
      check_gen("reset_hold", 1'b0, 4'b0000);
`ifdef EVEN_PARITY_CHECK_EN
      check("reset_chk_err", {31'd0, chk_err}, 32'd0);
`endif
    end

    // Sweep truth table, first value sampled on the release edge
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      A = vecs[i].a;
      step();
      check_gen($sformatf("sweep_%0d", i), vecs[i].exp_p, vecs[i].exp_out);
    end

    // Back-to-back 001 then 111
    A = 3'b001;
    step();
    check_gen("b2b_001", 1'b1, 4'b0011);
    A = 3'b111;
    step();
    check_gen("b2b_111", 1'b1, 4'b1111);

    // Mid-stream reset at A=110, then release with A=011
    A = 3'b110;
    step();
    check_gen("pre_rst_110", 1'b0, 4'b1100);
    rst = 1'b1;
    step();
    check_gen("mid_rst", 1'b0, 4'b0000);
    rst = 1'b0;
    A = 3'b011;
    step();
    check_gen("post_rst_011", 1'b0, 4'b0110);

`ifdef EVEN_PARITY_CHECK_EN
    chk_in = 4'b1011;
    step();
    check("chk_1011", {31'd0, chk_err}, 32'd1);
    chk_in = 4'b1001;
    step();
    check("chk_1001", {31'd0, chk_err}, 32'd0);
    // Loopback: feed the registered codeword back into the checker
    for (int i = 0; i < 8; i++) begin
      A = 3'(i);
      chk_in = Out;
      step();
      check($sformatf("loopback_%0d", i), {31'd0, chk_err}, 32'd0);
    end
    chk_in = Out;
    step();
    check("loopback_last", {31'd0, chk_err}, 32'd0);
`endif

    // Randomized stream with occasional reset
    for (int i = 0; i < 300; i++) begin
      r_a   = 3'($urandom_range(0, 7));
      r_rst = ($urandom_range(0, 15) == 0);
      A   = r_a;
      rst = r_rst;
`ifdef EVEN_PARITY_CHECK_EN
      chk_in = 4'($urandom_range(0, 15));
`endif
      ep = model_parity({29'd0, r_a}, 3);
`ifdef EVEN_PARITY_CHECK_EN
      begin
        logic ee;
        ee = r_rst ? 1'b0 : model_parity({28'd0, chk_in}, 4);
        step();
        check("rand_chk_err", {31'd0, chk_err}, {31'd0, ee});
      end
`else
      step();
`endif
      if (r_rst) check_gen("rand_rst", 1'b0, 4'b0000);
      else       check_gen("rand", ep, {r_a, ep});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/even_parity_fourbit.md
EVEN_PARITY_FOURBIT -- requirements
Module: even_parity_fourbit

Interface
REQ-001 Parameter DATA_W, default 3, number of data bits protected by the parity bit.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 A  input  DATA_W (3)  data word to be protected.
REQ-005 parity_bit  output  1  registered even-parity bit for A.
REQ-006 Out  output  DATA_W+1 (4)  registered codeword, Out = {A, parity_bit}: A in Out[3:1], parity in Out[0].
REQ-007 chk_in  input  DATA_W+1 (4)  codeword to check; present only when EVEN_PARITY_CHECK_EN is defined.
REQ-008 chk_err  output  1  registered parity-error flag; present only when EVEN_PARITY_CHECK_EN is defined.

Function
REQ-009 parity_bit SHALL be the XOR of all bits of A, so that Out always has an even number of ones.
REQ-010 parity_bit and Out SHALL be registered, updating on the rising clk edge that samples A; latency is one cycle.
REQ-011 A SHALL be sampled on every clock edge, with no enable or handshake; a new A value every cycle yields a new codeword every cycle.
REQ-012 Out[3:1] SHALL equal the sampled A bit-for-bit, and Out[0] SHALL equal parity_bit from the same cycle.
REQ-013 Truth table (A -> parity_bit, Out): 000->0,0000; 001->1,0011; 010->1,0101; 011->0,0110; 100->1,1001; 101->0,1010; 110->0,1100; 111->1,1111.
REQ-014 X/Z on A is not a supported input; outputs are undefined in that case, and no error signalling is required.

Reset
REQ-015 While rst=1 at a rising clk edge, parity_bit SHALL be 0, Out SHALL be 0000 and chk_err (if present) SHALL be 0.
REQ-016 Reset SHALL take priority over input sampling on the same edge.
REQ-017 On the first edge after rst deasserts, the outputs SHALL reflect the A sampled on that edge.
REQ-018 Asserting reset mid-stream SHALL discard the pending codeword without any glitch beyond the normal register update.

Configuration
REQ-019 Macro EVEN_PARITY_CHECK_EN, when defined, SHALL add chk_in and chk_err.
REQ-020 With EVEN_PARITY_CHECK_EN, chk_err SHALL be the registered XOR of all chk_in bits (1 = odd ones = error), with one-cycle latency and reset to 0.
REQ-021 Without EVEN_PARITY_CHECK_EN, chk_in and chk_err SHALL be absent, and the generator behaviour SHALL be identical to the enabled build.

Structure
REQ-022 Package even_parity_pkg SHALL hold DATA_W default, CW_W = DATA_W+1 and a codeword typedef of width CW_W.
REQ-023 Sub-module parity_tree SHALL be a parameterised, purely combinational XOR reduction.
REQ-024 parity_tree SHALL be instantiated once for the generator and once for the checker when EVEN_PARITY_CHECK_EN is enabled.
REQ-025 Only the top level even_parity_fourbit SHALL hold flops.

Verification
REQ-026 Hold rst=1 for 2 cycles with A=101 -> parity_bit=0, Out=0000 throughout reset.
REQ-027 Release reset and sweep A=000..111, one value per cycle -> each codeword matches REQ-013, one cycle after sampling.
REQ-028 A=001 applied for one cycle, then A=111 -> Out=0011 then 1111, parity_bit 1 then 1.
REQ-029 Assert rst during a stream at A=110 -> next edge Out=0000; after release with A=011, Out=0110.
REQ-030 Enabled build: chk_in=1011 -> chk_err=1 next cycle; chk_in=1001 -> chk_err=0; chk_in=Out loopback for all 8 A -> chk_err always 0.
REQ-031 Disabled build: compiles without chk_in and chk_err, and REQ-027 passes unchanged.
